// File: rtl/rr_grant_arbiter_16_pkg.sv
// rr_grant_arbiter_16_pkg: shared constants, state type and one-hot encode helper
//   for the 16-requester round-robin arbiter.
package rr_grant_arbiter_16_pkg;
   localparam int N_REQ = 16;
   localparam int PTR_W = 4;
   localparam logic [N_REQ-1:0] GRANT_NONE = 16'h0000;
   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} arb_state_e;
   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (oh[i]) idx = idx | PTR_W'(i);
      return idx;
   endfunction
endpackage

// File: rtl/rr_grant_arbiter_16_pick.sv
// rr_pick_16: combinational round-robin picker; first set req bit at or above ptr, wrapping 15->0.
//   req    : request vector
//   ptr    : search start index
//   onehot : selected requester (zero when req==0)
//   idx    : index of onehot
//   any    : req has any bit set
module rr_pick_16
   import rr_grant_arbiter_16_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [PTR_W-1:0] idx,
   output logic             any
);
   logic [2*N_REQ-1:0] dbl;
   logic [2*N_REQ-1:0] masked;
   logic [2*N_REQ-1:0] low;
   always_comb begin
      // lower copy masked below ptr, upper copy intact: the lowest surviving bit
      // is the first request at/above ptr, or the wrapped one in the upper copy
      dbl    = {req, req};
      masked = dbl & ~((32'd1 << ptr) - 32'd1);
      low    = masked & (~masked + 32'd1);
      onehot = low[N_REQ-1:0] | low[2*N_REQ-1:N_REQ];
      idx    = onehot_to_idx(onehot);
      any    = |req;
   end
endmodule

// File: rtl/rr_grant_arbiter_16.sv
// rr_grant_arbiter_16: 16-requester round-robin arbiter with registered one-hot grant
//   and valid/ready offer handshake.
//   clk, reset_n (async active-low)
//   arb_en      : allow new grants
//   req         : request vector
//   grant       : registered one-hot grant, zero when no offer
//   grant_valid : offer pending
//   grant_ready : consumer accepts the offer this cycle
//   busy        : grant_valid | any req
//   Option RR_GRANT_ARB_PRIO0_EN: requester 0 fixed highest priority, its grants leave ptr untouched.
module rr_grant_arbiter_16
   import rr_grant_arbiter_16_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             arb_en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             grant_valid,
   input  logic             grant_ready,
   output logic             busy
);
   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             accept;
   logic [PTR_W-1:0] ptr_adv;
   logic [PTR_W-1:0] pick_ptr;
   logic [N_REQ-1:0] rr_oh;
   logic [PTR_W-1:0] rr_idx;
   logic             rr_any;
   logic [N_REQ-1:0] pick_oh;
   logic             issue;

   rr_pick_16 u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .onehot (rr_oh),
      .idx    (rr_idx),
      .any    (rr_any)
   );

   always_comb begin
      accept = (state_q == OFFER) && grant_ready;
`ifdef RR_GRANT_ARB_PRIO0_EN
      // a requester-0 grant came from the fixed-priority path, not the rotation
      ptr_adv = grant_q[0] ? ptr_q : onehot_to_idx(grant_q) + PTR_W'(1);
      pick_oh = req[0] ? 16'h0001 : rr_oh;
`else
      ptr_adv = onehot_to_idx(grant_q) + PTR_W'(1);
      pick_oh = rr_oh;
`endif
      // on accept the follow-on pick already sees the advanced pointer
      pick_ptr = accept ? ptr_adv : ptr_q;
      issue    = arb_en && rr_any;
      ptr_d    = pick_ptr;
      state_d  = state_q;
      grant_d  = grant_q;
      if (state_q == IDLE || accept) begin
         state_d = issue ? OFFER : IDLE;
         grant_d = issue ? pick_oh : GRANT_NONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= GRANT_NONE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = (state_q == OFFER);
   assign busy        = grant_valid | (|req);
endmodule

// File: tb/tb_rr_grant_arbiter_16.sv
// tb_rr_grant_arbiter_16: directed self-checking bench for rr_grant_arbiter_16 (default build).
module tb_rr_grant_arbiter_16;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        arb_en;
   logic [15:0] req;
   logic [15:0] grant;
   logic        grant_valid;
   logic        grant_ready;
   logic        busy;
   int          vectors = 0;
   int          miscompares = 0;

   rr_grant_arbiter_16 dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .arb_en      (arb_en),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_ready (grant_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic offer(input string tag, input logic [15:0] g, input logic v);
      chk({tag, "_grant"}, grant, g);
      chk({tag, "_valid"}, {15'd0, grant_valid}, {15'd0, v});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; arb_en = 1'b1; req = 16'hFFFF; grant_ready = 1'b0;
      step(); step();
      offer("reset", 16'h0000, 1'b0);
      chk("reset_busy", {15'd0, busy}, 16'd1);
      reset_n = 1'b1;
      step();
      offer("first", 16'h0001, 1'b1);
      grant_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         offer($sformatf("rot%0d", i), 16'd1 << (i % 16), 1'b1);
      end
      arb_en = 1'b0;
      step();
      offer("en_off_accept", 16'h0000, 1'b0);
      arb_en = 1'b1; req = 16'h0120; grant_ready = 1'b0;
      step();
      offer("stall_first", 16'h0020, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         offer($sformatf("stall%0d", i), 16'h0020, 1'b1);
      end
      grant_ready = 1'b1;
      step();
      offer("stall_next", 16'h0100, 1'b1);
      step();
      offer("stall_wrap", 16'h0020, 1'b1);
      req = 16'h0008;
      step();
      offer("wd_offer", 16'h0008, 1'b1);
      grant_ready = 1'b0; req = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         step();
         offer($sformatf("wd_hold%0d", i), 16'h0008, 1'b1);
         chk("wd_busy", {15'd0, busy}, 16'd1);
      end
      grant_ready = 1'b1;
      step();
      offer("wd_done", 16'h0000, 1'b0);
      chk("idle_busy", {15'd0, busy}, 16'd0);
      grant_ready = 1'b0; arb_en = 1'b0; req = 16'h0004;
      step(); step();
      offer("en_off", 16'h0000, 1'b0);
      chk("en_off_busy", {15'd0, busy}, 16'd1);
      arb_en = 1'b1;
      step();
      offer("en_on_wrap", 16'h0004, 1'b1);
      reset_n = 1'b0;
      #1;
      offer("async_reset", 16'h0000, 1'b0);
      req = 16'hFFFF;
      step();
      reset_n = 1'b1;
      step();
      offer("post_reset", 16'h0001, 1'b1);
      grant_ready = 1'b1; req = 16'h0001;
      step();
      offer("lone_regrant", 16'h0001, 1'b1);
      req = 16'h8001;
      step();
      offer("after_lone", 16'h8000, 1'b1);
      step();
      offer("wrap_to0", 16'h0001, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
